wt64_prod_acc: RTL and testbench
================================

Name: wt64_prod_acc

Overview:
- Downstream consumer of the 64x64 Karatsuba/Wallace approximate multiplier.
- Takes the multiplier's unsigned 128-bit products one per handshake and accumulates a programmed number of them (dot-product / MAC reduction) into a wide register.
- Presents the final sum on a valid/ready output port, with a sticky overflow flag.

Parameters:
- PW, 128, product input width (2x multiplier operand width)
- AW, 136, accumulator/output width; must satisfy AW >= PW
- LENW, 16, width of the term-count field

Ports:
- clk, input, 1, single clock; all state updates on rising edge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, begin a new accumulation; sampled only in IDLE
- len, input, LENW, number of products to accumulate; sampled with start
- in_valid, input, 1, in_prod is valid
- in_ready, output, 1, block accepts a product this cycle
- in_prod, input, PW, unsigned product from the multiplier
- out_valid, output, 1, out_sum/out_count/ovf are final
- out_ready, input, 1, downstream accepts result
- out_sum, output, AW, accumulated sum
- out_count, output, LENW, number of products actually accumulated
- ovf, output, 1, sticky: the sum exceeded 2^AW-1 during this run
- busy, output, 1, high in ACCUM or HOLD

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_sum=0, out_count=0, ovf=0, in_ready=0, out_valid=0, busy=0.
  - Remaining counter=0.
  - Reset mid-run discards the run; no result is produced.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE, start=1, len!=0:
  - Next cycle: acc=0, count=0, ovf=0, remaining=len, state=ACCUM.
- IDLE, start=1, len==0:
  - Next cycle: acc=0, count=0, ovf=0, state=HOLD.
  - An empty run returns sum 0.
- IDLE, start=0: hold. out_sum/out_count/ovf retain the last result.
- ACCUM:
  - in_ready=1. On in_valid&in_ready: acc += zero_extend(in_prod); count += 1; remaining -= 1.
  - A carry out of bit AW-1 sets ovf. The sum wraps modulo 2^AW.
  - in_valid=0 cycles are bubbles: no change.
  - On the beat where remaining==1: state=HOLD next cycle, in_ready=0 from then on.
- HOLD:
  - out_valid=1, in_ready=0. out_sum includes the final product.
  - Latency: out_valid rises the cycle after the last accepted beat.
  - Outputs stay stable while out_valid&!out_ready.
  - On out_valid&out_ready: state=IDLE next cycle, out_valid=0. out_sum/out_count/ovf hold their values.
- start asserted in ACCUM or HOLD is ignored. len changes outside the IDLE start cycle are ignored.
- in_prod is never accepted outside ACCUM, regardless of in_valid.
- Count never exceeds len. No extra beats are consumed after the last one.
- The output handshake and a new start cannot coincide, because start is only honoured in IDLE.
  - The earliest next start is honoured the cycle after the out_valid&out_ready handshake.
- out_count == len at every HOLD.

Optional Feature:
- Macro: WT64_PROD_ACC_SAT_EN.
- Defined: on overflow the accumulator saturates to all-ones (2^AW-1). It stays saturated for the rest of the run, and ovf is set.
- Undefined: the accumulator wraps modulo 2^AW, and ovf is set.
- Ports are identical in both builds.

Test Plan:
- Reset mid-ACCUM: len=4, accept 2 beats, pulse rst_n low -> all outputs 0, state IDLE, no out_valid; a following start with len=1 works normally.
- Basic run: len=3, products 5, 7, 11 with no bubbles -> out_valid one cycle after the 3rd beat; out_sum=23, out_count=3, ovf=0.
- Bubbles and backpressure: len=2, in_valid gapped (1,0,0,1), products 2^127 and 2^127, out_ready low for 3 cycles -> out_sum=2^128 held stable; out_valid drops the cycle after out_ready=1.
- Empty run: start with len=0 -> HOLD next cycle; out_sum=0, out_count=0; in_ready never 1.
- Overflow without macro: len=257, every product 2^128-1 -> out_sum=2^128-257, ovf=1. With WT64_PROD_ACC_SAT_EN: out_sum=2^136-1, ovf=1.
- Ignored start plus excess input: start pulsed during ACCUM and HOLD, in_valid held high after the last beat -> run unaffected, out_count==len, extra products not consumed (in_ready=0).

Source files
------------

// File: rtl/wt64_prod_acc.sv
// Accumulates a programmed number of unsigned products into a wide sum (optional saturation: WT64_PROD_ACC_SAT_EN).
// Latency: out_valid rises the cycle after the last accepted product; an empty run (len=0) presents 0 the cycle after start.
// Backpressure: in_ready only in ACCUM; the result is held stable in HOLD until out_ready.
module wt64_prod_acc #(
    parameter int PW   = 128,
    parameter int AW   = 136,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [LENW-1:0] len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PW-1:0]   in_prod,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_sum,
    output logic [LENW-1:0] out_count,
    output logic            ovf,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_nxt;
    logic [LENW-1:0] count;
    logic [LENW-1:0] remaining;
    logic            ovf_q;
    logic [AW:0]     prod_ext;
    logic [AW:0]     sum_ext;
    logic            carry;
    logic            beat;

    assign beat = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && remaining == LENW'(1)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One extra bit on the adder exposes the carry out of bit AW-1.
    assign prod_ext = (AW+1)'(in_prod);
    assign sum_ext  = {1'b0, acc} + prod_ext;
    assign carry    = sum_ext[AW];

`ifdef WT64_PROD_ACC_SAT_EN
    // Once overflowed, pin at all-ones for the rest of the run.
    assign acc_nxt = (carry || ovf_q) ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
    assign acc_nxt = sum_ext[AW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            remaining <= '0;
            ovf_q     <= 1'b0;
        end else if (state == IDLE && start) begin
            acc       <= '0;
            count     <= '0;
            remaining <= len;
            ovf_q     <= 1'b0;
        end else if (beat) begin
            acc       <= acc_nxt;
            count     <= count + LENW'(1);
            remaining <= remaining - LENW'(1);
            ovf_q     <= ovf_q | carry;
        end
    end

    assign out_sum   = acc;
    assign out_count = count;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wt64_prod_acc.sv
// Directed-vector scoreboard bench for wt64_prod_acc: expectations queued at stimulus, popped by a monitor on each output handshake.
module tb_wt64_prod_acc;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  len;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_prod;
    logic         out_valid;
    logic         out_ready;
    logic [135:0] out_sum;
    logic [15:0]  out_count;
    logic         ovf;
    logic         busy;

    typedef struct packed {
        logic [135:0] sum;
        logic [15:0]  cnt;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [135:0] one136;
    logic [135:0] p2_128;
    logic [127:0] p2_127;
    logic [127:0] ones128;
    logic [135:0] ovf_exp;

    wt64_prod_acc #(.PW(128), .AW(136), .LENW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .ovf(ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0h with empty scoreboard", out_sum);
            end else begin
                mon_e = sb.pop_front();
                check("out_sum", out_sum, mon_e.sum);
                check("out_count", 136'(out_count), 136'(mon_e.cnt));
                check("ovf", 136'(ovf), 136'(mon_e.ovf));
            end
        end
    end

    task automatic start_run(input logic [15:0] n);
        int w;
        w = 0;
        while (busy && w < 1000) begin
            tick;
            w++;
        end
        if (busy) fail_now("wait_idle");
        start = 1'b1;
        len   = n;
        tick;
        start = 1'b0;
        len   = 16'h00ff;
    endtask

    task automatic send(input logic [127:0] p);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_prod  = p;
        @(negedge clk);
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) fail_now("send_accept");
        tick;
    endtask

    task automatic push(input logic [135:0] s, input logic [15:0] c, input logic o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        sb.push_back(e);
    endtask

    initial begin
        one136  = 136'd1;
        p2_128  = one136 << 128;
        p2_127  = 128'd1 << 127;
        ones128 = {128{1'b1}};
`ifdef WT64_PROD_ACC_SAT_EN
        ovf_exp = {136{1'b1}};
`else
        ovf_exp = p2_128 - 136'd257;
`endif
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_prod = '0; out_ready = 1'b1;
        #3;
        check("rst_out_sum", out_sum, 136'd0);
        check("rst_out_valid", 136'(out_valid), 136'd0);
        check("rst_in_ready", 136'(in_ready), 136'd0);
        check("rst_busy", 136'(busy), 136'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Reset in the middle of an accumulation
        start_run(16'd4);
        send(128'd9);
        send(128'd13);
        in_valid = 1'b0;
        check("mid_busy", 136'(busy), 136'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_sum", out_sum, 136'd0);
        check("midrst_out_count", 136'(out_count), 136'd0);
        check("midrst_ovf", 136'(ovf), 136'd0);
        check("midrst_in_ready", 136'(in_ready), 136'd0);
        check("midrst_out_valid", 136'(out_valid), 136'd0);
        check("midrst_busy", 136'(busy), 136'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        push(136'd5, 16'd1, 1'b0);
        start_run(16'd1);
        send(128'd5);
        in_valid = 1'b0;
        tick;

        // Basic run, no bubbles
        push(136'd23, 16'd3, 1'b0);
        start_run(16'd3);
        send(128'd5);
        send(128'd7);
        send(128'd11);
        in_valid = 1'b0;
        @(negedge clk);
        check("basic_latency_out_valid", 136'(out_valid), 136'd1);
        check("basic_in_ready_low", 136'(in_ready), 136'd0);
        tick;

        // Bubbles and output backpressure
        out_ready = 1'b0;
        push(p2_128, 16'd2, 1'b0);
        start_run(16'd2);
        send(p2_127);
        in_valid = 1'b0;
        tick;
        tick;
        send(p2_127);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 136'(out_valid), 136'd1);
            check("bp_out_sum_stable", out_sum, p2_128);
            tick;
        end
        out_ready = 1'b1;
        tick;
        @(negedge clk);
        check("bp_out_valid_drop", 136'(out_valid), 136'd0);
        check("bp_sum_retained", out_sum, p2_128);
        tick;

        // Empty run
        push(136'd0, 16'd0, 1'b0);
        start_run(16'd0);
        @(negedge clk);
        check("empty_out_valid", 136'(out_valid), 136'd1);
        check("empty_in_ready", 136'(in_ready), 136'd0);
        tick;

        // Overflow: 257 x (2^128-1)
        push(ovf_exp, 16'd257, 1'b1);
        start_run(16'd257);
        for (int i = 0; i < 257; i++) send(ones128);
        in_valid = 1'b0;
        tick;

        // Start ignored in ACCUM/HOLD, excess input not consumed
        out_ready = 1'b0;
        push(136'd6, 16'd3, 1'b0);
        start_run(16'd3);
        send(128'd1);
        start = 1'b1;
        len   = 16'd9;
        send(128'd2);
        start = 1'b0;
        send(128'd3);
        in_prod = 128'd100;
        start   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("xs_in_ready_hold", 136'(in_ready), 136'd0);
            check("xs_out_count_hold", 136'(out_count), 136'd3);
            check("xs_out_sum_hold", out_sum, 136'd6);
            tick;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick;
        @(negedge clk);
        check("xs_idle_in_ready", 136'(in_ready), 136'd0);
        check("xs_idle_busy", 136'(busy), 136'd0);
        check("xs_idle_sum", out_sum, 136'd6);
        in_valid = 1'b0;
        tick;
        tick;

        check("scoreboard_drained", 136'(sb.size()), 136'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
